muldiv_unit: RTL

- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, for the pipelined CPU's EX stage.
- Replaces the single-cycle combinational multiply/divide with a fixed-latency multiplier, an iterative radix-2 divider, a start/busy handshake and a cancel input.
- The hazard unit stalls any HI/LO access while busy=1.

---
 rtl/muldiv_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module     : muldiv_unit
// Description: Multi-cycle multiply/divide unit with HI/LO registers.
//              Optional multiply-accumulate ops are enabled by MULDIV_MADD_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CNT_BASE = $clog2(WIDTH) + 1;
    localparam int CNT_MUL  = $clog2(MUL_CYCLES + 1) + 1;
    localparam int CNT_W    = (CNT_BASE > CNT_MUL) ? CNT_BASE : CNT_MUL;

    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_MULT  = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;
    localparam logic [3:0] OP_MTHI  = 4'b0110;
`ifdef MULDIV_MADD_EN
    localparam logic [3:0] OP_MADDU = 4'b1000;
    localparam logic [3:0] OP_MADD  = 4'b1001;
    localparam logic [3:0] OP_MSUBU = 4'b1010;
    localparam logic [3:0] OP_MSUB  = 4'b1011;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Multiplier path: operands extended to 2*WIDTH, product truncated mod 2^(2*WIDTH)
    logic                 mul_signed;
    logic [2*WIDTH-1:0]   mul_a_ext, mul_b_ext, product, mul_result;

`ifdef MULDIV_MADD_EN
    assign mul_signed = op_q[3] ? op_q[0] : (op_q == OP_MULT);
    assign mul_result = !op_q[3] ? product :
                        (op_q[1] ? ({hi_q, lo_q} - product) : ({hi_q, lo_q} + product));
`else
    assign mul_signed = (op_q == OP_MULT);
    assign mul_result = product;
`endif

    assign mul_a_ext = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign mul_b_ext = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign product   = mul_a_ext * mul_b_ext;

    // Restoring divider step on magnitudes; b_q holds the divisor magnitude in DIV
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     rem_shift, rem_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   quo_next, rem_next, quo_res, rem_res;

    assign a_neg     = (op_i == OP_DIV) & a_i[WIDTH-1];
    assign b_neg     = (op_i == OP_DIV) & b_i[WIDTH-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, b_q};
    assign div_ge    = ~rem_diff[WIDTH];
    assign quo_next  = {quo_q[WIDTH-2:0], div_ge};
    assign rem_next  = div_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_res   = negq_q ? -quo_next : quo_next;
    assign rem_res   = negr_q ? -rem_next : rem_next;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !cancel_i) begin
                    case (op_i)
                        OP_MULTU, OP_MULT: begin
                            state_d = S_MUL;
                            cnt_d   = CNT_W'(MUL_CYCLES - 1);
                            op_d    = op_i;
                            a_d     = a_i;
                            b_d     = b_i;
                        end
`ifdef MULDIV_MADD_EN
                        OP_MADDU, OP_MADD, OP_MSUBU, OP_MSUB: begin
                            state_d = S_MUL;
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            op_d    = op_i;
                            a_d     = a_i;
                            b_d     = b_i;
                        end
`endif
                        OP_DIVU, OP_DIV: begin
                            state_d = S_DIV;
                            cnt_d   = CNT_W'(WIDTH - 1);
                            op_d    = op_i;
                            a_d     = a_i;
                            b_d     = b_mag;
                            quo_d   = a_mag;
                            rem_d   = '0;
                            negq_d  = a_neg ^ b_neg;
                            negr_d  = a_neg;
                        end
                        OP_MTLO: lo_d = a_i;
                        OP_MTHI: hi_d = a_i;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = mul_result;
                    state_d      = S_IDLE;
                    done_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DIV: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    quo_d = quo_next;
                    rem_d = rem_next;
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        // Divide by zero returns all-ones quotient and the raw dividend
                        if (b_q == '0) begin
                            lo_d = '1;
                            hi_d = a_q;
                        end else begin
                            lo_d = quo_res;
                            hi_d = rem_res;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
`default_nettype wire
